// File: rtl/ptp_loopback_latency.sv
// ptp_loopback_latency
//
// Pairs TX and RX PTP timestamps (96-bit: [95:48] sec, [47:16] ns, [15:0] fns)
// and reports per-frame TX->RX latency in ns / fractional ns. It also keeps
// min / max / count / error statistics for loopback characterisation.
//
// Ports
//   clk, rst                     logic clock, asynchronous active-low reset
//   s_axis_tx_ptp_ts_*           TX timestamp stream into the pairing FIFO
//   s_axis_rx_ptp_ts_*           RX timestamp stream; each one pops a TX entry
//   m_axis_lat_*                 latency result stream (ns, fns, err)
//   clear_stats                  synchronous clear of the statistics
//   lat_min_ns / lat_max_ns      min / max latency of good samples
//   sample_count / error_count   saturating good / error sample counters
//   rx_orphan                    one-cycle pulse: RX arrived with FIFO empty
//
// Handshake semantics (all three streams): a transfer happens on a rising
// clk edge where valid && ready. A producer holding valid keeps its data
// stable until the transfer. On the result stream, valid and data are
// registered and hold until ready; ready never depends combinationally on
// the same stream's valid.
//
// Pipeline: RX handshake (cycle N) -> stage 1 register (subtract) ->
// combinational correction -> output register (valid in cycle N+2).
module ptp_loopback_latency #(
  parameter int TS_FIFO_DEPTH = 16,
  parameter int LAT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [95:0]          s_axis_tx_ptp_ts_96,
  input  logic                 s_axis_tx_ptp_ts_valid,
  output logic                 s_axis_tx_ptp_ts_ready,
  input  logic [95:0]          s_axis_rx_ptp_ts_96,
  input  logic                 s_axis_rx_ptp_ts_valid,
  output logic                 s_axis_rx_ptp_ts_ready,
  output logic [LAT_WIDTH-1:0] m_axis_lat_ns,
  output logic [15:0]          m_axis_lat_fns,
  output logic                 m_axis_lat_err,
  output logic                 m_axis_lat_valid,
  input  logic                 m_axis_lat_ready,
  input  logic                 clear_stats,
  output logic [LAT_WIDTH-1:0] lat_min_ns,
  output logic [LAT_WIDTH-1:0] lat_max_ns,
  output logic [31:0]          sample_count,
  output logic [15:0]          error_count,
  output logic                 rx_orphan
);

  localparam int AW = $clog2(TS_FIFO_DEPTH);
  localparam logic [AW:0] FIFO_FULL_COUNT = (AW + 1)'(TS_FIFO_DEPTH);

  // Largest latency representable in LAT_WIDTH bits; anything above it is
  // reported as an error rather than silently truncated.
  localparam logic [63:0] LAT_LIMIT =
    (LAT_WIDTH >= 64) ? {64{1'b1}} : ((64'd1 << LAT_WIDTH) - 64'd1);

  localparam logic signed [33:0] NS_PER_SEC = 34'sd1_000_000_000;

  // ---------------------------------------------------------------------
  // TX timestamp FIFO
  // ---------------------------------------------------------------------
  logic [95:0]   fifo_mem [TS_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          tx_push;
  logic          rx_hs;
  logic          rx_pop;
  logic [95:0]   tx_head;

  // Full / empty come straight from the occupancy register, so a pop while
  // full only raises ready in the following cycle, and a push into an empty
  // FIFO is only visible to RX in the following cycle.
  assign fifo_full  = (fifo_count == FIFO_FULL_COUNT);
  assign fifo_empty = (fifo_count == '0);

  assign s_axis_tx_ptp_ts_ready = !fifo_full;
  assign tx_push = s_axis_tx_ptp_ts_valid && !fifo_full;
  assign rx_hs   = s_axis_rx_ptp_ts_valid && s_axis_rx_ptp_ts_ready;
  assign rx_pop  = rx_hs && !fifo_empty;
  assign tx_head = fifo_mem[rd_ptr];

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (tx_push) begin
      fifo_mem[wr_ptr] <= s_axis_tx_ptp_ts_96;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (tx_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rx_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({tx_push, rx_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Orphan RX pulse
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_orphan <= 1'b0;
    end else begin
      rx_orphan <= rx_hs && fifo_empty;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: field-wise subtraction
  // ---------------------------------------------------------------------
  logic [47:0] sub_dsec;
  logic [16:0] sub_dfns;
  logic [32:0] sub_dns;

  // fns borrow propagates into the ns difference; dns is kept as a 33-bit
  // two's-complement value so a negative result survives to stage 2.
  assign sub_dsec = s_axis_rx_ptp_ts_96[95:48] - tx_head[95:48];
  assign sub_dfns = {1'b0, s_axis_rx_ptp_ts_96[15:0]} - {1'b0, tx_head[15:0]};
  assign sub_dns  = {1'b0, s_axis_rx_ptp_ts_96[47:16]} - {1'b0, tx_head[47:16]}
                    - {32'd0, sub_dfns[16]};

  logic        s1_valid;
  logic [47:0] s1_dsec;
  logic [15:0] s1_fns;
  logic [32:0] s1_dns;
  logic        out_can_load;
  logic        s1_fire;

  // Output register accepts new data when empty or draining this cycle.
  assign out_can_load = !m_axis_lat_valid || m_axis_lat_ready;
  assign s1_fire      = s1_valid && out_can_load;

  // RX is only blocked when both stage 1 and the output register are full
  // and the output is stalled.
  assign s_axis_rx_ptp_ts_ready = !s1_valid || out_can_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_dsec  <= '0;
      s1_fns   <= '0;
      s1_dns   <= '0;
    end else begin
      if (rx_pop) begin
        s1_valid <= 1'b1;
        s1_dsec  <= sub_dsec;
        s1_fns   <= sub_dfns[15:0];
        s1_dns   <= sub_dns;
      end else if (s1_fire) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: second-boundary correction and range check (combinational)
  // ---------------------------------------------------------------------
  logic signed [33:0] dns_ext;
  logic signed [33:0] corr_ns;
  logic [33:0]        corr_mag;
  logic               corr_err;
  logic [LAT_WIDTH-1:0] res_ns;
  logic [15:0]          res_fns;

  assign dns_ext  = $signed({s1_dns[32], s1_dns});
  assign corr_mag = corr_ns;

  always_comb begin
    corr_ns  = dns_ext;
    corr_err = 1'b0;
    if (s1_dsec == 48'd0) begin
      corr_ns = dns_ext;
    end else if (s1_dsec == 48'd1) begin
      corr_ns = dns_ext + NS_PER_SEC;
    end else begin
      // RX earlier than TX by whole seconds, or more than one second apart.
      corr_err = 1'b1;
    end
    if (corr_ns[33]) begin
      corr_err = 1'b1;
    end
    if ({30'd0, corr_mag} > LAT_LIMIT) begin
      corr_err = 1'b1;
    end
  end

  always_comb begin
    res_ns  = LAT_WIDTH'(corr_mag);
    res_fns = s1_fns;
    if (corr_err) begin
      res_ns  = '1;
      res_fns = '1;
    end
  end

  // ---------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_axis_lat_valid <= 1'b0;
      m_axis_lat_ns    <= '0;
      m_axis_lat_fns   <= '0;
      m_axis_lat_err   <= 1'b0;
    end else begin
      if (s1_fire) begin
        m_axis_lat_valid <= 1'b1;
        m_axis_lat_ns    <= res_ns;
        m_axis_lat_fns   <= res_fns;
        m_axis_lat_err   <= corr_err;
      end else if (m_axis_lat_ready) begin
        m_axis_lat_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Statistics, updated on the result handshake
  // ---------------------------------------------------------------------
  logic out_hs;
  assign out_hs = m_axis_lat_valid && m_axis_lat_ready;

  // clear_stats takes priority: a sample delivered in the clearing cycle is
  // still transferred but not counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_min_ns   <= '1;
      lat_max_ns   <= '0;
      sample_count <= '0;
      error_count  <= '0;
    end else if (clear_stats) begin
      lat_min_ns   <= '1;
      lat_max_ns   <= '0;
      sample_count <= '0;
      error_count  <= '0;
    end else if (out_hs) begin
      if (m_axis_lat_err) begin
        if (error_count != 16'hFFFF) begin
          error_count <= error_count + 16'd1;
        end
      end else begin
        if (sample_count != 32'hFFFF_FFFF) begin
          sample_count <= sample_count + 32'd1;
        end
        if (m_axis_lat_ns < lat_min_ns) begin
          lat_min_ns <= m_axis_lat_ns;
        end
        if (m_axis_lat_ns > lat_max_ns) begin
          lat_max_ns <= m_axis_lat_ns;
        end
      end
    end
  end

endmodule
